kbd_text_writer: RTL
====================

KBD_TEXT_WRITER -- requirements
Module: kbd_text_writer

Interface
REQ-001 SHALL have parameter ADDR_W, default 11, text-RAM address width.
REQ-002 SHALL have parameter BASE_ADDR, default 118, first writable cell and cursor home.
REQ-003 SHALL have parameter END_ADDR, default 2047, last writable cell; BASE_ADDR < END_ADDR <= 2^ADDR_W-1.
REQ-004 SHALL have parameter COLS, default 80, cells per text row.
REQ-005 SHALL have parameters BS_CODE (8'h66), ENTER_CODE (8'h5A), BLANK_CHAR (8'h20), CURSOR_CHAR (8'hFF).
REQ-006 SHALL have clk, input, 1, sole clock; all state on its rising edge.
REQ-007 SHALL have rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have data, input, 8, scancode from keyboard decoder.
REQ-009 SHALL have valid, input, 1, one-cycle strobe qualifying data/released.
REQ-010 SHALL have released, input, 1, 1 = break code, 0 = make code.
REQ-011 SHALL have addr, output, ADDR_W, RAM write address (registered).
REQ-012 SHALL have din, output, 8, RAM write data (registered).
REQ-013 SHALL have wen, output, 1, RAM write enable, one cycle per write.
REQ-014 SHALL have busy, output, 1, high while an accepted event is in progress.
REQ-015 SHALL have cursor, output, ADDR_W, current cursor address.

Function
REQ-016 SHALL implement FSM IDLE -> WR1 -> (WR2 when KBD_CURSOR_EN) -> IDLE.
REQ-017 SHALL accept an event only in IDLE with valid=1 and released=0; break codes and valid while busy SHALL be dropped with no write and no cursor change.
REQ-018 Printable (data not BS_CODE/ENTER_CODE): WR1 writes data at cursor, then cursor advances one cell.
REQ-019 BS_CODE: cursor steps back one cell (no move at BASE_ADDR); WR1 writes BLANK_CHAR at new cursor.
REQ-020 ENTER_CODE: cursor moves to column 0 of next row; WR1 writes BLANK_CHAR at old cursor when KBD_CURSOR_EN, else WR1 has wen=0.
REQ-021 SHALL track column counter 0..COLS-1 alongside cursor; advance from COLS-1 sets column 0; backspace from column 0 sets COLS-1.
REQ-022 Any cursor move past END_ADDR SHALL wrap to BASE_ADDR with column 0.
REQ-023 Latency: valid accepted at edge N gives wen=1 in cycle N+1; cursor updates at same edge as WR1.
REQ-024 busy SHALL be 1 from the cycle after acceptance through the last write cycle, 0 in IDLE.
REQ-025 wen SHALL be 0 in IDLE; addr/din SHALL hold last values when wen=0.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, cursor=BASE_ADDR, column=0, addr=BASE_ADDR, din=0, wen=0, busy=0, including mid-sequence.
REQ-027 First event after rst release SHALL behave as from home position.

Configuration
REQ-028 Macro KBD_CURSOR_EN defined: WR2 follows every WR1 writing CURSOR_CHAR at new cursor; busy spans 2 cycles.
REQ-029 KBD_CURSOR_EN undefined: no WR2, no marker writes, busy spans 1 cycle; ENTER produces no write.

Verification
REQ-030 Reset, make 8'h1C -> wen at addr 118 din 8'h1C, cursor 119; break 8'h1C -> no write.
REQ-031 81 printable makes from reset (COLS=80) -> cursor 199, column 1; BS twice -> blanks written at 198 then 197, cursor 197.
REQ-032 BS at reset -> cursor stays 118, BLANK_CHAR written at 118.
REQ-033 Cursor 130 (column 12), ENTER -> cursor 198; with KBD_CURSOR_EN writes 8'h20@130 then 8'hFF@198.
REQ-034 END_ADDR=127 instance, 10 makes from reset -> last write at 127, cursor wraps to 118; valid during busy ignored.
REQ-035 rst asserted during WR1 -> wen drops same cycle, cursor 118, next make writes at 118.

Source files
------------

// File: rtl/kbd_text_writer.sv
// Keyboard-to-text-RAM writer: turns make codes into character writes and moves a text cursor.
// Optional macro KBD_CURSOR_EN adds a second write that places CURSOR_CHAR at the new cursor.
module kbd_text_writer #(
    parameter int          ADDR_W      = 11,
    parameter int          BASE_ADDR   = 118,
    parameter int          END_ADDR    = 2047,
    parameter int          COLS        = 80,
    parameter logic [7:0]  BS_CODE     = 8'h66,
    parameter logic [7:0]  ENTER_CODE  = 8'h5A,
    parameter logic [7:0]  BLANK_CHAR  = 8'h20,
    parameter logic [7:0]  CURSOR_CHAR = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        data,
    input  logic              valid,
    input  logic              released,
    output logic [ADDR_W-1:0] addr,
    output logic [7:0]        din,
    output logic              wen,
    output logic              busy,
    output logic [ADDR_W-1:0] cursor
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(END_ADDR);
    localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);

    typedef enum logic [1:0] {IDLE, WR1, WR2} state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ADDR_W-1:0]  cursor_d, addr_d;
    logic [7:0]         din_d;
    logic               wen_d;
    logic [31:0]        enter_nxt;

    assign busy = (state_q != IDLE);

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        state_d   = state_q;
        cursor_d  = cursor;
        col_d     = col_q;
        addr_d    = addr;
        din_d     = din;
        wen_d     = 1'b0;
        enter_nxt = 32'(cursor) + 32'(COLS) - 32'(col_q);

        unique case (state_q)
            IDLE: begin
                if (valid && !released) begin
                    state_d = WR1;
                    if (data == BS_CODE) begin
                        if (cursor != BASE) begin
                            cursor_d = cursor - 1'b1;
                            col_d    = (col_q == '0) ? LAST_COL : col_q - 1'b1;
                        end
                        wen_d  = 1'b1;
                        addr_d = cursor_d;
                        din_d  = BLANK_CHAR;
                    end else if (data == ENTER_CODE) begin
                        col_d = '0;
                        if (enter_nxt > 32'(END_ADDR)) cursor_d = BASE;
                        else                           cursor_d = enter_nxt[ADDR_W-1:0];
`ifdef KBD_CURSOR_EN
                        // Erase the marker left at the old position.
                        wen_d  = 1'b1;
                        addr_d = cursor;
                        din_d  = BLANK_CHAR;
`endif
                    end else begin
                        if (cursor == LAST) begin
                            cursor_d = BASE;
                            col_d    = '0;
                        end else begin
                            cursor_d = cursor + 1'b1;
                            col_d    = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
                        end
                        wen_d  = 1'b1;
                        addr_d = cursor;
                        din_d  = data;
                    end
                end
            end
            WR1: begin
`ifdef KBD_CURSOR_EN
                // cursor already holds the post-move position here.
                state_d = WR2;
                wen_d   = 1'b1;
                addr_d  = cursor;
                din_d   = CURSOR_CHAR;
`else
                state_d = IDLE;
`endif
            end
            WR2:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cursor  <= BASE;
            col_q   <= '0;
            addr    <= BASE;
            din     <= '0;
            wen     <= 1'b0;
        end else begin
            state_q <= state_d;
            cursor  <= cursor_d;
            col_q   <= col_d;
            addr    <= addr_d;
            din     <= din_d;
            wen     <= wen_d;
        end
    end

endmodule
